// File: rtl/pwm_pkg.sv
// Shared constants, FSM encoding and saturating step arithmetic for the duty key controller.
package pwm_pkg;
  localparam int DUTY_W   = 10;
  localparam int NUM_KEYS = 2;
  localparam int KEY_UP   = 0;
  localparam int KEY_DOWN = 1;
  localparam int TIMER_W  = 25;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_HOLD   = 2'd2,
    S_REPEAT = 2'd3
  } state_e;

  // 11-bit intermediate on the way up so an overflow clamps instead of wrapping
  function automatic logic [DUTY_W-1:0] duty_step(input logic [DUTY_W-1:0] d,
                                                  input logic dn,
                                                  input logic [DUTY_W-1:0] step);
    logic [DUTY_W:0] sum;
    sum = {1'b0, d} + {1'b0, step};
    if (dn) return (d < step) ? '0 : d - step;
    return (sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : sum[DUTY_W-1:0];
  endfunction
endpackage

// File: rtl/pwm_duty_keyctl_if.sv
// Key/duty bundle between the button front-end and its user (PWM stage / bench).
interface pwm_duty_keyctl_if;
  import pwm_pkg::*;
  logic [NUM_KEYS-1:0] key_n;
  logic [DUTY_W-1:0]   duty;
  logic                duty_upd;
  logic [NUM_KEYS-1:0] key_db;

  modport master (output key_n, input duty, duty_upd, key_db);
  modport slave  (input key_n, output duty, duty_upd, key_db);
endinterface

// File: rtl/pwm_duty_keyctl_key_debounce.sv
// One key: 2-flop synchroniser (idles released) followed by a hold-time debouncer.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_db
);
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          lvl;

  assign lvl = ~sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= 2'b11;
      cnt    <= '0;
      key_db <= 1'b0;
    end else begin
      sync <= {sync[0], key_n};
      if (lvl == key_db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        key_db <= ~key_db;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pwm_duty_keyctl.sv
// Up/down buttons to a saturating 10-bit duty word with press step and hold auto-repeat.
module pwm_duty_keyctl
  import pwm_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int HOLD_CYC     = 25000000,
  parameter int REPEAT_CYC   = 2500000,
  parameter int STEP         = 8,
  parameter logic [DUTY_W-1:0] DUTY_INIT = 10'h3F8
) (
  input  logic              clk,
  input  logic              rst,
  pwm_duty_keyctl_if.slave  bus
);
  logic [NUM_KEYS-1:0] key_db;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk   (clk),
      .rst   (rst),
      .key_n (bus.key_n[k]),
      .key_db(key_db[k])
    );
  end

  state_e              state, state_nxt;
  logic [NUM_KEYS-1:0] held, held_nxt;
  logic [TIMER_W-1:0]  timer, timer_nxt;
  logic                step_fire;
  logic [DUTY_W-1:0]   duty, duty_new;
  logic                duty_upd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      held  <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      held  <= held_nxt;
      timer <= timer_nxt;
    end
  end

  // held is the key pattern that started the press; any other pattern ends it
  always_comb begin
    state_nxt = state;
    held_nxt  = held;
    timer_nxt = timer;
    step_fire = 1'b0;
    case (state)
      S_IDLE: begin
        if ($onehot(key_db)) begin
          state_nxt = S_STEP;
          held_nxt  = key_db;
        end
      end
      S_STEP: begin
        step_fire = 1'b1;
        timer_nxt = TIMER_W'(HOLD_CYC - 1);
        state_nxt = S_HOLD;
      end
      S_HOLD, S_REPEAT: begin
        if (key_db != held) begin
          state_nxt = S_IDLE;
        end else if (timer == '0) begin
          step_fire = 1'b1;
          timer_nxt = TIMER_W'(REPEAT_CYC - 1);
          state_nxt = S_REPEAT;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign duty_new = duty_step(duty, held[KEY_DOWN], DUTY_W'(STEP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty     <= DUTY_INIT;
      duty_upd <= 1'b0;
    end else begin
      duty_upd <= step_fire && (duty_new != duty);
      if (step_fire) duty <= duty_new;
    end
  end

  assign bus.duty     = duty;
  assign bus.duty_upd = duty_upd;
  assign bus.key_db   = key_db;
endmodule

// File: tb/tb_pwm_duty_keyctl.sv
// Bench: randomized key presses against a press-age based reference model of the controller.
module tb_pwm_duty_keyctl;
  localparam int D  = 4;
  localparam int HC = 20;
  localparam int RC = 5;
  localparam int ST = 8;
  localparam logic [9:0] INIT = 10'h3F8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  pwm_duty_keyctl_if ifc();

  pwm_duty_keyctl #(.DEBOUNCE_CYC(D), .HOLD_CYC(HC), .REPEAT_CYC(RC), .STEP(ST), .DUTY_INIT(INIT))
    dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  always #5 clk = ~clk;

  // Reference: a key is accepted once its synced level has disagreed for D cycles in a row.
  // A single-key pattern held for `age` cycles steps at age 1, at age 1+HC, then every RC.
  logic [1:0] m_s1, m_s2, m_db;
  int         m_run [2];
  int         m_age;
  int         m_duty;
  logic       m_upd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = 2'b11; m_s2 = 2'b11; m_db = 2'b00;
      m_run[0] = 0; m_run[1] = 0;
      m_age = 0; m_duty = INIT; m_upd = 1'b0;
    end else begin : mdl
      int nd; bit fire; logic [1:0] prev; logic lvl;
      prev = m_db;
      fire = (m_db == 2'b01 || m_db == 2'b10) &&
             (m_age == 1 || (m_age >= HC + 1 && (m_age - HC - 1) % RC == 0));
      nd = m_duty;
      if (fire) nd = m_db[1] ? ((m_duty < ST) ? 0 : m_duty - ST)
                             : ((m_duty + ST > 1023) ? 1023 : m_duty + ST);
      m_upd  = fire && (nd != m_duty);
      m_duty = nd;
      for (int k = 0; k < 2; k++) begin
        lvl = ~m_s2[k];
        m_run[k] = (lvl != m_db[k]) ? m_run[k] + 1 : 0;
        if (m_run[k] == D) begin
          m_db[k]  = lvl;
          m_run[k] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = ifc.key_n;
      m_age = (m_db == prev) ? m_age + 1 : 0;
    end
  end

  task automatic test_reset();
    ifc.key_n = 2'b11;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ifc.duty, ifc.duty_upd, ifc.key_db} !== {INIT, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL reset_state got duty=%h upd=%b db=%b exp duty=%h upd=0 db=00",
               ifc.duty, ifc.duty_upd, ifc.key_db, INIT);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(negedge clk); checks++;
      if ({ifc.duty, ifc.duty_upd, ifc.key_db} !== {10'(m_duty), m_upd, m_db}) begin
        errors++;
        $display("FAIL reset_idle t=%0t got %h/%b/%b exp %h/%b/%b", $time,
                 ifc.duty, ifc.duty_upd, ifc.key_db, 10'(m_duty), m_upd, m_db);
      end
    end
  endtask

  task automatic test_bounce();
    ifc.key_n = 2'b10;
    repeat (3) @(negedge clk);
    ifc.key_n = 2'b11;
    repeat (12) begin
      @(negedge clk); checks++;
      if ({ifc.duty, ifc.duty_upd, ifc.key_db} !== {INIT, 1'b0, 2'b00}) begin
        errors++;
        $display("FAIL bounce t=%0t got %h/%b/%b exp %h/0/00", $time,
                 ifc.duty, ifc.duty_upd, ifc.key_db, INIT);
      end
    end
  endtask

  // Single clean presses (one step each) until the reference duty reaches target.
  task automatic go_to(input int target);
    int tries = 0;
    while (m_duty != target && tries < 200) begin
      ifc.key_n = (target > m_duty) ? 2'b10 : 2'b01;
      for (int c = 0; c < 22; c++) begin
        if (c == 10) ifc.key_n = 2'b11;
        @(negedge clk); checks++;
        if ({ifc.duty, ifc.duty_upd, ifc.key_db} !== {10'(m_duty), m_upd, m_db}) begin
          errors++;
          $display("FAIL go_to t=%0t got %h/%b/%b exp %h/%b/%b", $time,
                   ifc.duty, ifc.duty_upd, ifc.key_db, 10'(m_duty), m_upd, m_db);
        end
      end
      tries++;
    end
    checks++;
    if (ifc.duty !== 10'(target)) begin
      errors++;
      $display("FAIL go_to_reach got duty=%h exp %h", ifc.duty, 10'(target));
    end
  endtask

  // Hold pattern kn for hold cycles, then release for rel cycles; returns pulse count.
  task automatic press(input logic [1:0] kn, input int hold, input int rel, output int n);
    n = 0;
    ifc.key_n = kn;
    for (int c = 0; c < hold + rel; c++) begin
      if (c == hold) ifc.key_n = 2'b11;
      @(negedge clk); checks++;
      n += int'(ifc.duty_upd);
      if ({ifc.duty, ifc.duty_upd, ifc.key_db} !== {10'(m_duty), m_upd, m_db}) begin
        errors++;
        $display("FAIL press t=%0t key_n=%b got %h/%b/%b exp %h/%b/%b", $time, kn,
                 ifc.duty, ifc.duty_upd, ifc.key_db, 10'(m_duty), m_upd, m_db);
      end
    end
  endtask

  task automatic test_single_press();
    int n;
    go_to(10'h100);
    press(2'b10, 10, 12, n);
    checks++;
    if (n !== 1 || ifc.duty !== 10'h108) begin
      errors++;
      $display("FAIL single_press got pulses=%0d duty=%h exp pulses=1 duty=108", n, ifc.duty);
    end
  endtask

  task automatic test_hold_repeat();
    int n;
    go_to(10'h100);
    press(2'b10, 60, 12, n);
    checks++;
    if (n !== 9 || ifc.duty !== 10'(10'h100 + 8 * n)) begin
      errors++;
      $display("FAIL hold_repeat got pulses=%0d duty=%h exp pulses=9 duty=148", n, ifc.duty);
    end
  endtask

  task automatic test_saturate();
    int n;
    go_to(10'h3F8);
    press(2'b10, 40, 12, n);
    checks++;
    if (n !== 1 || ifc.duty !== 10'h3FF) begin
      errors++;
      $display("FAIL sat_top got pulses=%0d duty=%h exp pulses=1 duty=3ff", n, ifc.duty);
    end
    go_to(0);
    press(2'b01, 40, 12, n);
    checks++;
    if (n !== 0 || ifc.duty !== 10'h000) begin
      errors++;
      $display("FAIL sat_bottom got pulses=%0d duty=%h exp pulses=0 duty=000", n, ifc.duty);
    end
  endtask

  task automatic test_both_keys();
    int n, n2;
    go_to(10'h100);
    press(2'b00, 30, 0, n);
    press(2'b01, 14, 12, n2);
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL both_no_step got pulses=%0d exp 0", n);
    end
    checks++;
    if (n2 !== 1 || ifc.duty !== 10'h0F8) begin
      errors++;
      $display("FAIL both_rearm got pulses=%0d duty=%h exp pulses=1 duty=0f8", n2, ifc.duty);
    end
  endtask

  task automatic test_random();
    int n, kind, hold;
    repeat (25) begin
      kind = $urandom_range(0, 3);
      hold = $urandom_range(6, 70);
      case (kind)
        0: press(2'b10, hold, $urandom_range(8, 20), n);
        1: press(2'b01, hold, $urandom_range(8, 20), n);
        2: begin
          press(2'b00, hold, 0, n);
          press($urandom_range(0, 1) ? 2'b01 : 2'b10, $urandom_range(5, 30),
                $urandom_range(8, 20), n);
        end
        default: press($urandom_range(0, 1) ? 2'b01 : 2'b10, $urandom_range(1, 3), 10, n);
      endcase
    end
  endtask

  task automatic test_mid_reset();
    int n;
    go_to(10'h100);
    ifc.key_n = 2'b10;
    repeat (35) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ifc.duty, ifc.duty_upd, ifc.key_db} !== {INIT, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL mid_reset got duty=%h upd=%b db=%b exp duty=%h upd=0 db=00",
               ifc.duty, ifc.duty_upd, ifc.key_db, INIT);
    end
    @(negedge clk); rst = 1'b0;
    press(2'b10, 20, 12, n);
    checks++;
    if (n !== 1 || ifc.duty !== 10'h3FF) begin
      errors++;
      $display("FAIL mid_reset_redebounce got pulses=%0d duty=%h exp pulses=1 duty=3ff",
               n, ifc.duty);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_single_press();
    test_hold_repeat();
    test_saturate();
    test_both_keys();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
